// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by uart_rx and uart_tx_buffered.
// Holds the frame state encoding, the data width and the bit-timing helper.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  // 3-bit state encoding; PARITY is only reachable when parity is built in.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Clocks per UART bit from system clock and baud rate.
  function automatic int calc_clks_per_bit(input int f_clk, input int baud);
    return f_clk / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: single-clock elastic buffer in front of the UART transmitter.
// Writes while full and pops while empty are ignored; a write and a pop on
// the same edge both take effect and leave the count unchanged.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        wr_en_i,
  input  logic [UART_DATA_BITS-1:0]   wr_data_i,
  input  logic                        rd_en_i,
  output logic [UART_DATA_BITS-1:0]   rd_data_o,
  output logic                        full_o,
  output logic                        empty_o,
  output logic [$clog2(FIFO_DEPTH):0] count_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [UART_DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]          wr_ptr_q;
  logic [PTR_W-1:0]          rd_ptr_q;
  logic [PTR_W:0]            count_q;
  logic                      do_wr;
  logic                      do_rd;

  assign full_o    = (count_q == (PTR_W+1)'(FIFO_DEPTH));
  assign empty_o   = (count_q == '0);
  assign do_wr     = wr_en_i && !full_o;
  assign do_rd     = rd_en_i && !empty_o;
  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

  // Pointer and occupancy bookkeeping; depth is a power of two so pointers wrap naturally.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: buffered 8N1 UART transmitter for the dds-synth host link.
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit after
// data bit 7 (8E1 framing); without it the frame is 8N1.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int F_CLK        = 12_000_000,
  parameter int UART_BAUD    = 9600,
  parameter int CLKS_PER_BIT = calc_clks_per_bit(F_CLK, UART_BAUD),
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       SER_CLK,
  input  logic       RST_N,
  input  logic       TX_DV,
  input  logic [7:0] TX_BYTE,
  output logic       TX_READY,
  output logic       TX_SERIAL,
  output logic       TX_ACTIVE,
  output logic       TX_DONE,
  output logic       TX_EMPTY
);

  localparam logic [31:0] CNT_LAST = 32'(CLKS_PER_BIT - 1);
  // Cycle before the last stop cycle: TX_DONE is registered, so it is set one edge early.
  localparam logic [31:0] CNT_PRE  = 32'(CLKS_PER_BIT - 2);
  localparam logic [2:0]  BIT_LAST = 3'(UART_DATA_BITS - 1);

  uart_state_e               state_q;
  logic [31:0]               clk_cnt_q;
  logic [2:0]                bit_idx_q;
  logic [UART_DATA_BITS-1:0] shift_q;
  logic                      tx_serial_q;
  logic                      tx_done_q;
`ifdef UART_TX_PARITY_EN
  logic                      parity_q;
`endif

  logic                      fifo_pop;
  logic [UART_DATA_BITS-1:0] fifo_rdata;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  uart_tx_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (SER_CLK),
    .rst_ni    (RST_N),
    .wr_en_i   (TX_DV),
    .wr_data_i (TX_BYTE),
    .rd_en_i   (fifo_pop),
    .rd_data_o (fifo_rdata),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

  // A new frame is loaded from idle, or directly at the end of a stop bit for back-to-back frames.
  always_comb begin
    fifo_pop = 1'b0;
    if (!fifo_empty &&
        ((state_q == ST_IDLE) || ((state_q == ST_STOP) && (clk_cnt_q == CNT_LAST)))) begin
      fifo_pop = 1'b1;
    end
  end

  // Frame sequencer: walks start, data, optional parity and stop bits with registered line output.
  always_ff @(posedge SER_CLK) begin
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      clk_cnt_q   <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      tx_serial_q <= 1'b1;
      tx_done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      tx_done_q <= (state_q == ST_STOP) && (clk_cnt_q == CNT_PRE);
      case (state_q)
        ST_IDLE: begin
          clk_cnt_q <= '0;
          bit_idx_q <= '0;
          if (fifo_pop) begin
            shift_q     <= fifo_rdata;
`ifdef UART_TX_PARITY_EN
            parity_q    <= ^fifo_rdata;
`endif
            tx_serial_q <= 1'b0;
            state_q     <= ST_START;
          end else begin
            tx_serial_q <= 1'b1;
          end
        end
        ST_START: begin
          if (clk_cnt_q == CNT_LAST) begin
            clk_cnt_q   <= '0;
            bit_idx_q   <= '0;
            tx_serial_q <= shift_q[0];
            state_q     <= ST_DATA;
          end else begin
            clk_cnt_q <= clk_cnt_q + 32'd1;
          end
        end
        ST_DATA: begin
          if (clk_cnt_q == CNT_LAST) begin
            clk_cnt_q <= '0;
            if (bit_idx_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
              tx_serial_q <= parity_q;
              state_q     <= ST_PARITY;
`else
              tx_serial_q <= 1'b1;
              state_q     <= ST_STOP;
`endif
            end else begin
              bit_idx_q   <= bit_idx_q + 3'd1;
              tx_serial_q <= shift_q[bit_idx_q + 3'd1];
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + 32'd1;
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (clk_cnt_q == CNT_LAST) begin
            clk_cnt_q   <= '0;
            tx_serial_q <= 1'b1;
            state_q     <= ST_STOP;
          end else begin
            clk_cnt_q <= clk_cnt_q + 32'd1;
          end
        end
`endif
        ST_STOP: begin
          if (clk_cnt_q == CNT_LAST) begin
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            if (fifo_pop) begin
              shift_q     <= fifo_rdata;
`ifdef UART_TX_PARITY_EN
              parity_q    <= ^fifo_rdata;
`endif
              tx_serial_q <= 1'b0;
              state_q     <= ST_START;
            end else begin
              tx_serial_q <= 1'b1;
              state_q     <= ST_IDLE;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + 32'd1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          clk_cnt_q   <= '0;
          bit_idx_q   <= '0;
          tx_serial_q <= 1'b1;
        end
      endcase
    end
  end

  assign TX_SERIAL = tx_serial_q;
  assign TX_DONE   = tx_done_q;
  assign TX_ACTIVE = (state_q != ST_IDLE);
  assign TX_READY  = !fifo_full;
  assign TX_EMPTY  = (fifo_count == '0) && (state_q == ST_IDLE);

endmodule
